// File: rtl/multicycle_cpu_core.sv
// rtl/multicycle_cpu_core.sv - multi-cycle CPU core: imem, PC, register file, 4-op ALU
//
// Purpose: runs a program from a side-loaded instruction memory, one
// instruction per FETCH -> DECODE -> EXEC -> WB pass, until the all-ones
// HALT word is decoded. Program and registers are loaded while idle.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   start                 run request pulse, honoured in IDLE/HALT
//   prog_we/addr/data     instruction memory write port (IDLE/HALT only)
//   reg_we/addr/wdata     register file load port (IDLE/HALT only)
//   reg_rdata             combinational read of reg[reg_addr]
//   inst_out              instruction register
//   wb_en/addr/data       write-back strobe, destination and result
//   carry, zero           ALU flags, updated in EXEC
//   busy, done            executing / halted status
module multicycle_cpu_core #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 2,
  parameter int PC_W   = 4,
  localparam int INST_W = 2 + 3 * RA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [INST_W-1:0] prog_data,
  input  logic              reg_we,
  input  logic [RA_W-1:0]   reg_addr,
  input  logic [DATA_W-1:0] reg_wdata,
  output logic [DATA_W-1:0] reg_rdata,
  output logic [INST_W-1:0] inst_out,
  output logic              wb_en,
  output logic [RA_W-1:0]   wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              carry,
  output logic              zero,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  state_t state, next_state;

  logic [INST_W-1:0] imem [2**PC_W];
  logic [DATA_W-1:0] regs [2**RA_W];
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] op_a, op_b, result;
  logic              halt_q;

  logic [1:0]        op;
  logic [RA_W-1:0]   dest, src1, src2;
  logic              idle_ok;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic [DATA_W:0]   alu_wide;

  assign op   = inst_out[INST_W-1 -: 2];
  assign dest = inst_out[3*RA_W-1 -: RA_W];
  assign src1 = inst_out[2*RA_W-1 -: RA_W];
  assign src2 = inst_out[RA_W-1:0];

  assign idle_ok   = (state == S_IDLE) || (state == S_HALT);
  assign busy      = !idle_ok;
  assign done      = (state == S_HALT);
  assign wb_en     = (state == S_WB);
  assign wb_addr   = dest;
  assign wb_data   = result;
  assign reg_rdata = regs[reg_addr];

  // One extra bit so the carry-out of ADD and the borrow of SUB fall
  // out of the same top bit.
  always_comb begin
    alu_wide = '0;
    alu_res  = '0;
    alu_c    = 1'b0;
    case (op)
      2'b00: begin
        alu_wide = {1'b0, op_a} + {1'b0, op_b};
        alu_res  = alu_wide[DATA_W-1:0];
        alu_c    = alu_wide[DATA_W];
      end
      2'b01: begin
        alu_wide = {1'b0, op_a} - {1'b0, op_b};
        alu_res  = alu_wide[DATA_W-1:0];
        alu_c    = alu_wide[DATA_W];
      end
      2'b10:   alu_res = op_a & op_b;
      default: alu_res = op_a | op_b;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_HALT: if (start) next_state = S_FETCH;
      S_FETCH:        next_state = S_DECODE;
      S_DECODE:       next_state = S_EXEC;
      // A decoded HALT still occupies the EXEC slot (without touching
      // the flags), so HALT is entered three cycles after its FETCH.
      S_EXEC:         next_state = halt_q ? S_HALT : S_WB;
      S_WB:           next_state = S_FETCH;
      default:        next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= '0;
      inst_out <= '0;
      op_a     <= '0;
      op_b     <= '0;
      result   <= '0;
      halt_q   <= 1'b0;
      carry    <= 1'b0;
      zero     <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        S_IDLE, S_HALT: if (start) pc <= '0;
        S_FETCH: inst_out <= imem[pc];
        S_DECODE: begin
          op_a   <= regs[src1];
          op_b   <= regs[src2];
          halt_q <= (inst_out == '1);
        end
        S_EXEC: if (!halt_q) begin
          result <= alu_res;
          carry  <= alu_c;
          zero   <= (alu_res == '0);
        end
        S_WB: pc <= pc + PC_W'(1);
        default: ;
      endcase
    end
  end

  // Register file: WB and the side load port are mutually exclusive by state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**RA_W; i++) regs[i] <= '0;
    end else if (state == S_WB) begin
      regs[dest] <= result;
    end else if (idle_ok && reg_we) begin
      regs[reg_addr] <= reg_wdata;
    end
  end

  // Instruction memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (prog_we && idle_ok) imem[prog_addr] <= prog_data;
  end

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// tb/tb_multicycle_cpu_core.sv - directed self-checking bench for multicycle_cpu_core
module tb_multicycle_cpu_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic       reg_we = 1'b0;
  logic [1:0] reg_addr = '0;
  logic [7:0] reg_wdata = '0;
  logic [7:0] reg_rdata;
  logic [7:0] inst_out;
  logic       wb_en;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic       carry, zero, busy, done;

  int total = 0;
  int bad = 0;

  multicycle_cpu_core #(.DATA_W(8), .RA_W(2), .PC_W(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .inst_out(inst_out),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .carry(carry), .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_inst(input logic [3:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic load_reg(input logic [1:0] a, input logic [7:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge clk);
    reg_we = 1'b0;
  endtask

  task automatic read_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
    reg_addr = a;
    #1;
    check(tag, reg_rdata, exp);
  endtask

  // Returns at the negedge after start is sampled: state is FETCH.
  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_wb(input string tag);
    int n = 0;
    while (wb_en !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_wb_seen"}, wb_en, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done, 1);
  endtask

  // Test 1 program (r0 = r1 + r2, then HALT), counting cycles from FETCH entry.
  // With disturb set, every side strobe is pulsed while the core is busy.
  task automatic run_add(input string tag, input bit disturb);
    pulse_start;                         // c=0 FETCH
    @(negedge clk);                      // c=1 DECODE
    if (disturb) begin
      start = 1'b1;
      prog_we = 1'b1; prog_addr = 4'd1; prog_data = 8'h00;
      reg_we = 1'b1; reg_addr = 2'd1; reg_wdata = 8'd7;
    end
    @(negedge clk);                      // c=2 EXEC
    start = 1'b0; prog_we = 1'b0; reg_we = 1'b0;
    @(negedge clk);                      // c=3 WB
    check({tag, "_wb_en"}, wb_en, 1);
    check({tag, "_wb_addr"}, wb_addr, 0);
    check({tag, "_wb_data"}, wb_data, 44);
    check({tag, "_carry"}, carry, 1);
    check({tag, "_zero"}, zero, 0);
    repeat (3) @(negedge clk);           // c=6 EXEC of HALT word
    check({tag, "_done_c6"}, done, 0);
    @(negedge clk);                      // c=7 HALT
    check({tag, "_done_c7"}, done, 1);
    check({tag, "_busy_c7"}, busy, 0);
  endtask

  initial begin
    int bad_run;

    // Reset state
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_inst", inst_out, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_rdata", reg_rdata, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1. ADD with carry
    load_reg(2'd1, 8'd200);
    load_reg(2'd2, 8'd100);
    load_inst(4'd0, 8'h06);
    load_inst(4'd1, 8'hFF);
    run_add("add", 1'b0);
    read_reg("add_r0", 2'd0, 8'd44);

    // 2. SUB giving zero, then SUB with borrow
    load_reg(2'd1, 8'd5);
    load_reg(2'd2, 8'd5);
    load_inst(4'd0, 8'h46);
    pulse_start;
    wait_wb("sub0");
    check("sub0_addr", wb_addr, 0);
    check("sub0_data", wb_data, 0);
    check("sub0_zero", zero, 1);
    check("sub0_carry", carry, 0);
    wait_done("sub0");

    load_reg(2'd2, 8'd3);
    load_inst(4'd0, 8'h59);
    pulse_start;
    wait_wb("subb");
    check("subb_addr", wb_addr, 1);
    check("subb_data", wb_data, 254);
    check("subb_carry", carry, 1);
    check("subb_zero", zero, 0);
    wait_done("subb");

    // 3. Back-to-back dependency
    load_reg(2'd1, 8'd1);
    load_reg(2'd2, 8'd2);
    load_inst(4'd0, 8'h06);
    load_inst(4'd1, 8'hC0);
    load_inst(4'd2, 8'h30);
    load_inst(4'd3, 8'hFF);
    pulse_start;
    wait_done("dep");
    read_reg("dep_r0", 2'd0, 8'd3);
    read_reg("dep_r3", 2'd3, 8'd6);

    // 4. PC wrap over 16 non-HALT words imem[i] = 0x10 | i
    for (int i = 0; i < 16; i++) load_inst(4'(i), 8'h10 | 8'(i));
    pulse_start;
    bad_run = 0;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);                    // DECODE of instruction k
      if (k == 15) check("wrap_i15", inst_out, 8'h1F);
      if (k == 16) check("wrap_i16", inst_out, 8'h10);
      if (k < 16) begin
        repeat (3) begin
          @(negedge clk);
          if (busy !== 1'b1 || done !== 1'b0) bad_run++;
        end
      end
    end
    check("wrap_busy_run", bad_run, 0);

    // 5. Reset while in EXEC of the 17th instruction
    @(negedge clk);                      // EXEC
    reg_addr = 2'd0;
    reset = 1'b1;
    #1;
    check("xrst_inst", inst_out, 0);
    check("xrst_wb_en", wb_en, 0);
    check("xrst_wb_addr", wb_addr, 0);
    check("xrst_wb_data", wb_data, 0);
    check("xrst_flags", {carry, zero}, 0);
    check("xrst_busy", busy, 0);
    check("xrst_done", done, 0);
    check("xrst_r0", reg_rdata, 0);
    @(negedge clk);
    check("xrst_wb_hold", wb_en, 0);
    reset = 1'b0;
    bad_run = 0;
    repeat (2) begin
      @(negedge clk);
      if (wb_en !== 1'b0 || busy !== 1'b0) bad_run++;
    end
    check("xrst_idle", bad_run, 0);
    read_reg("xrst_r1", 2'd1, 8'd0);
    pulse_start;
    @(negedge clk);
    check("imem_kept", inst_out, 8'h10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    load_reg(2'd1, 8'd200);
    load_reg(2'd2, 8'd100);
    load_inst(4'd0, 8'h06);
    load_inst(4'd1, 8'hFF);
    run_add("rerun", 1'b0);

    // 6. Strobes while busy have no effect
    run_add("dist", 1'b1);
    read_reg("dist_r1", 2'd1, 8'd200);
    read_reg("dist_r2", 2'd2, 8'd100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
